// File: rtl/status_text_writer.sv
// Status-bar text writer: converts score/health/level to a 16-char ASCII line once per frame
// (double-dabble per field) and serves it through a char_xy -> char_code read port.
module status_text_writer #(
    parameter int unsigned SCORE_W    = 16,
    parameter logic [6:0]  BLANK_CODE = 7'h20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vblnk_in,
    input  logic [SCORE_W-1:0] score,
    input  logic [6:0]         health,
    input  logic [3:0]         level,
    input  logic [7:0]         char_xy,
    output logic [6:0]         char_code,
    output logic               busy,
    output logic               frame_updated
);

    typedef enum logic [2:0] {StIdle, StLoad, StShift, StWrite, StCommit} state_e;

    state_e             state_q, state_d;
    logic               vblnk_q;
    logic [SCORE_W-1:0] score_q;
    logic [6:0]         health_q;
    logic [3:0]         level_q;
    logic [1:0]         field_q;
    logic [3:0]         cnt_q;
    logic [15:0]        bin_q;
    logic [19:0]        bcd_q;
    logic               frame_updated_q;
    logic [6:0]         front_q [16];
    logic [6:0]         back_q  [16];

    logic        vblnk_rise;
    logic [15:0] load_val;
    logic [19:0] bcd_adj;
    logic [35:0] dd_shift;
    logic [3:0]  dig [5];
    logic        blank_s4, blank_s3, blank_s2, blank_s1;
    logic        blank_h2, blank_h1;

    function automatic logic [6:0] to_ascii(input logic [3:0] d);
        return 7'h30 + {3'b000, d};
    endfunction

    assign vblnk_rise = vblnk_in && !vblnk_q;

    always_comb begin
        load_val = {12'd0, level_q};
        case (field_q)
            2'd0:    load_val = 16'(score_q);
            2'd1:    load_val = {9'd0, health_q};
            default: load_val = {12'd0, level_q};
        endcase
    end

    // Double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left by one.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        dd_shift = {bcd_adj, bin_q} << 1;
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            dig[i] = bcd_q[4*i +: 4];
        end
        blank_s4 = (dig[4] == 4'd0);
        blank_s3 = blank_s4 && (dig[3] == 4'd0);
        blank_s2 = blank_s3 && (dig[2] == 4'd0);
        blank_s1 = blank_s2 && (dig[1] == 4'd0);
        blank_h2 = (dig[2] == 4'd0);
        blank_h1 = blank_h2 && (dig[1] == 4'd0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (vblnk_rise) state_d = StLoad;
            StLoad:   state_d = StShift;
            StShift:  if (cnt_q == 4'd15) state_d = StWrite;
            StWrite:  state_d = (field_q < 2'd2) ? StLoad : StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= StIdle;
            vblnk_q         <= 1'b1;
            score_q         <= '0;
            health_q        <= '0;
            level_q         <= '0;
            field_q         <= '0;
            cnt_q           <= '0;
            bin_q           <= '0;
            bcd_q           <= '0;
            frame_updated_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                front_q[i] <= BLANK_CODE;
                back_q[i]  <= BLANK_CODE;
            end
        end else begin
            state_q         <= state_d;
            vblnk_q         <= vblnk_in;
            frame_updated_q <= (state_q == StCommit);
            case (state_q)
                StIdle: begin
                    if (vblnk_rise) begin
                        score_q  <= score;
                        health_q <= health;
                        level_q  <= level;
                        field_q  <= 2'd0;
                    end
                end
                StLoad: begin
                    bin_q <= load_val;
                    bcd_q <= '0;
                    cnt_q <= '0;
                end
                StShift: begin
                    bcd_q <= dd_shift[35:16];
                    bin_q <= dd_shift[15:0];
                    cnt_q <= cnt_q + 4'd1;
                end
                StWrite: begin
                    case (field_q)
                        2'd0: begin
                            back_q[0] <= blank_s4 ? BLANK_CODE : to_ascii(dig[4]);
                            back_q[1] <= blank_s3 ? BLANK_CODE : to_ascii(dig[3]);
                            back_q[2] <= blank_s2 ? BLANK_CODE : to_ascii(dig[2]);
                            back_q[3] <= blank_s1 ? BLANK_CODE : to_ascii(dig[1]);
                            back_q[4] <= to_ascii(dig[0]);
                        end
                        2'd1: begin
                            back_q[6] <= blank_h2 ? BLANK_CODE : to_ascii(dig[2]);
                            back_q[7] <= blank_h1 ? BLANK_CODE : to_ascii(dig[1]);
                            back_q[8] <= to_ascii(dig[0]);
                        end
                        default: begin
                            back_q[10] <= to_ascii(dig[1]);
                            back_q[11] <= to_ascii(dig[0]);
                        end
                    endcase
                    if (field_q < 2'd2) field_q <= field_q + 2'd1;
                end
                StCommit: begin
                    for (int i = 0; i < 16; i++) begin
                        front_q[i] <= back_q[i];
                    end
                end
                default: ;
            endcase
        end
    end

    assign char_code     = (char_xy[7:4] == 4'd0) ? front_q[char_xy[3:0]] : BLANK_CODE;
    assign busy          = (state_q != StIdle);
    assign frame_updated = frame_updated_q;

endmodule

// File: tb/tb_status_text_writer.sv
// Bench for status_text_writer: stimulus pushes expected lines, a monitor reads the front
// buffer back on each frame_updated pulse and compares it against the queue head.
`timescale 1ns/1ps
module tb_status_text_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblnk_in;
    logic [15:0] score;
    logic [6:0]  health;
    logic [3:0]  level;
    logic [7:0]  char_xy, stim_xy, mon_xy;
    logic        mon_active;
    logic [6:0]  char_code;
    logic        busy;
    logic        frame_updated;

    int    n_tests = 0;
    int    n_fails = 0;
    string exp_q[$];

    always #5 clk = ~clk;

    assign char_xy = mon_active ? mon_xy : stim_xy;

    status_text_writer #(
        .SCORE_W    (16),
        .BLANK_CODE (7'h20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .vblnk_in      (vblnk_in),
        .score         (score),
        .health        (health),
        .level         (level),
        .char_xy       (char_xy),
        .char_code     (char_code),
        .busy          (busy),
        .frame_updated (frame_updated)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic read_cell(input string name, input logic [7:0] xy, input logic [6:0] exp);
        stim_xy = xy;
        #1;
        check(name, {25'd0, char_code}, {25'd0, exp});
    endtask

    task automatic start_frame(input int s, input int h, input int l, input string e,
                               input bit push);
        @(negedge clk);
        score    = s[15:0];
        health   = h[6:0];
        level    = l[3:0];
        vblnk_in = 1'b0;
        @(negedge clk);
        vblnk_in = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        #1;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (n >= 200) check("busy_timeout", n, 0);
    endtask

    // Monitor: on each commit pulse, read row 0 and compare against the scoreboard head.
    initial begin
        string e;
        mon_active = 1'b0;
        mon_xy     = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (frame_updated === 1'b1) begin
                check("commit_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    mon_active = 1'b1;
                    for (int c = 0; c < 16; c++) begin
                        mon_xy = {4'h0, c[3:0]};
                        #0.5;
                        check($sformatf("line col%0d", c), {25'd0, char_code}, {24'd0, e[c]});
                    end
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        rst      = 1'b0;
        vblnk_in = 1'b0;
        score    = '0;
        health   = '0;
        level    = '0;
        stim_xy  = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset frame_updated", frame_updated, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 16; c++) read_cell("reset blank", {4'h0, c[3:0]}, 7'h20);

        // Frame A: mid-range values with leading-zero blanking.
        start_frame(1234, 100, 7, " 1234 100 07    ", 1'b1);
        wait_done(n);
        check("A busy cycles", n, 55);
        check("A pulse", frame_updated, 1);
        @(posedge clk);
        #1;
        check("A pulse width", frame_updated, 0);
        repeat (3) @(posedge clk);

        // Frame B: maxima and zero health.
        start_frame(65535, 0, 15, "65535   0 15    ", 1'b1);
        wait_done(n);
        check("B busy cycles", n, 55);
        repeat (3) @(posedge clk);
        read_cell("row1 col3", 8'h13, 7'h20);
        read_cell("separator col5", 8'h05, 7'h20);
        read_cell("row1 col0", 8'h10, 7'h20);
        read_cell("rowF col4", 8'hF4, 7'h20);
        read_cell("row0 col0", 8'h00, 7'h36);

        // Frame C: score changes at E10 and a second vblank edge at E20 are both ignored.
        start_frame(42, 5, 3, "   42   5 03    ", 1'b1);
        repeat (9) @(posedge clk);
        #1 score = 16'd999;
        repeat (6) @(posedge clk);
        #1 vblnk_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 vblnk_in = 1'b1;
        wait_done(n);
        check("C busy remaining", n, 36);
        repeat (10) @(posedge clk);
        #1;
        check("C no restart", busy, 0);

        // Reset at E30 of a conversion, released while vblank is still high.
        start_frame(500, 50, 9, "", 1'b0);
        repeat (29) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("midreset busy", busy, 0);
        check("midreset frame_updated", frame_updated, 0);
        for (int c = 0; c < 16; c++) read_cell("midreset blank", {4'h0, c[3:0]}, 7'h20);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("release in vblank idle", busy, 0);

        // Frame D: correct output after reset.
        start_frame(0, 127, 0, "    0 127 00    ", 1'b1);
        wait_done(n);
        check("D busy cycles", n, 55);
        repeat (5) @(posedge clk);
        check("scoreboard drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/status_text_writer.md
# status_text_writer

Writer side of the status-bar text path. It converts the live game values `score`, `health` and `level` into a 16-character ASCII line buffer, and serves that buffer through a `char_xy` → `char_code` read port. The port is pin-compatible with the static text ROMs feeding `draw_rect_char`/`font_rom`. The line is recomputed once per frame at the start of vertical blanking and committed atomically, so the visible text never tears mid-frame.

## Interface
Parameters:
- `SCORE_W`, 16: score width; the score field shows 5 decimal digits.
- `BLANK_CODE`, 7'h20: ASCII space, used for unused and blanked cells.

Ports:
- `clk`  in  1  pixel clock, shared with the `draw_rect_char` chain.
- `rst`  in  1  reset; synchronous, active-low.
- `vblnk_in`  in  1  vertical blank from the timing chain; its rising edge triggers an update.
- `score`  in  SCORE_W  unsigned score, 0..65535.
- `health`  in  7  unsigned health, 0..127.
- `level`  in  4  unsigned level, 0..15.
- `char_xy`  in  8  read address `{row[3:0], col[3:0]}` from `draw_rect_char`.
- `char_code`  out  7  ASCII code of the cell; combinational from the front buffer.
- `busy`  out  1  conversion in progress.
- `frame_updated`  out  1  one-cycle pulse when the front buffer is committed.

## Operation
- Line layout by column:
  - cols 0–4: score, 5 digits.
  - col 5: space.
  - cols 6–8: health, 3 digits.
  - col 9: space.
  - cols 10–11: level, 2 digits.
  - cols 12–15: space.
- Read port:
  - `char_code = front[col]` when `row == 0`.
  - `char_code = BLANK_CODE` for any other row.
- Leading-zero blanking applies to score and health: leading zero digits become `BLANK_CODE`, but the least-significant digit is always shown. Level always shows 2 digits (e.g. "07").
- Digit encoding: ASCII = 7'h30 + BCD digit.
- FSM states: IDLE, LOAD, SHIFT, WRITE, COMMIT.
  - IDLE: on a rising edge of `vblnk_in` (`vblnk_in=1`, `vblnk_q=0`), snapshot `score`, `health`, `level` into registers, set field index = 0, go to LOAD.
  - LOAD: zero-extend the selected snapshot to 16 bits into the binary shifter, clear the 20-bit BCD register and the iteration counter, go to SHIFT.
  - SHIFT: double-dabble, one iteration per cycle. Each iteration adds 3 to every BCD nibble that is ≥5, then shifts `{bcd, bin}` left by 1. Exactly 16 iterations, then go to WRITE.
  - WRITE: write the field's digits, with blanking applied, into the back buffer. If field index < 2, increment it and go to LOAD; otherwise go to COMMIT.
  - COMMIT: copy back → front in one cycle, pulse `frame_updated`, go to IDLE.
- Inputs are sampled only at the snapshot. Later input changes affect the next frame only.
- A rising edge of `vblnk_in` while not IDLE is ignored. No restart and no queuing: that frame is skipped.

## Timing
- E0 is the clock edge that detects the `vblnk_in` rising edge.
- Field f (0 = score, 1 = health, 2 = level) occupies edges E(1+18f) through E(18+18f): LOAD, 16× SHIFT, WRITE.
- COMMIT happens at E55.
  - `front` changes at E55.
  - `busy` is 1 after E0 through E55, and 0 after E55.
  - `frame_updated` is 1 for exactly the cycle following E55.
- `char_code` follows `char_xy` combinationally, so the registered `font_rom` latency downstream is unchanged.
- Reset (`rst=0` at a clock edge) takes effect at that edge, including mid-conversion:
  - state = IDLE, `busy = 0`, `frame_updated = 0`.
  - front and back buffers = all `BLANK_CODE`.
  - `vblnk_q = 1`, so a release during vblank does not trigger an update until the next rising edge.
  - Snapshots and counters = 0.
- Width rules:
  - Health and level are zero-extended to 16 bits, which yields a 5-digit BCD; only the low 3 or 2 digits are written.
  - Maximum values cannot overflow: 65535 fits in 5 digits, 127 in 3, 15 in 2.

## Test plan
- Reset release, then read cols 0–15 of row 0 → all 7'h20; `busy = 0`.
- Set score=1234, health=100, level=7, then a `vblnk_in` rising edge → at E56 the line reads " 1234 100 07    ". `busy` is high for 55 cycles; `frame_updated` is a single pulse.
- Set score=65535, health=0, level=15 → "65535   0 15    ". This checks maximum values and that a zero health still shows "0".
- Second `vblnk_in` rising edge at E20, and score changed at E10 → no restart, and the committed score is the E0 snapshot.
- Assert `rst=0` at E30 of a conversion → `busy=0` and all cells blank at the next cycle. A later vblank edge then produces correct output.
- `char_xy = 8'h13` (row 1) → 7'h20 regardless of buffer contents. `char_xy = 8'h05` → 7'h20 (separator column).
